// File: rtl/reg_key_sequencer.sv
// Keypad command sequencer: turns debounced key presses into register read
// requests (REG, idx) and register writes (WRITE, idx, decimal digits, ENTER).
module reg_key_sequencer #(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_strobe,
  input  logic [3:0]        key_code,
  output logic              isreg,
  output logic [2:0]        regvalue,
  output logic              wr_en,
  output logic [2:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              err
);

  // Accumulator is wide enough for max_value*10+9, so the range check is exact.
  localparam int ACC_MAX = ((2 ** DATA_W) - 1) * 10 + 9;
  localparam int ACC_W   = $clog2(ACC_MAX + 1);
  localparam int CNT_W   = $clog2(MAX_DIGITS + 1);

  localparam logic [ACC_W-1:0] TEN      = ACC_W'(10);
  localparam logic [ACC_W-1:0] DATA_MAX = ACC_W'((2 ** DATA_W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);

  localparam logic [3:0] KEY_REG   = 4'hA;
  localparam logic [3:0] KEY_WRITE = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_CLEAR = 4'hD;

  typedef enum logic [1:0] {IDLE, RD_IDX, WR_IDX, WR_DATA} state_t;

  state_t             state_q, state_d;
  logic [2:0]         addr_q, addr_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               isreg_d, wr_en_d, err_d;
  logic [2:0]         regvalue_d, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_d;
  logic               is_digit, is_idx, is_cmd;

  assign is_digit = (key_code <= 4'd9);
  assign is_idx   = (key_code <= 4'd7);
  assign is_cmd   = (key_code == KEY_REG) || (key_code == KEY_WRITE) ||
                    (key_code == KEY_ENTER);
  assign acc_next = acc_q * TEN + {{(ACC_W-4){1'b0}}, key_code};
  assign busy     = (state_q != IDLE);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    isreg_d    = 1'b0;
    wr_en_d    = 1'b0;
    err_d      = 1'b0;
    regvalue_d = regvalue;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;

    if (key_strobe) begin
      if (key_code == KEY_CLEAR) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (key_code == KEY_REG)        state_d = RD_IDX;
            else if (key_code == KEY_WRITE) state_d = WR_IDX;
          end
          RD_IDX: begin
            if (is_idx) begin
              isreg_d    = 1'b1;
              regvalue_d = key_code[2:0];
              state_d    = IDLE;
            end else if (is_digit || is_cmd) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          WR_IDX: begin
            if (is_idx) begin
              addr_d  = key_code[2:0];
              acc_d   = '0;
              cnt_d   = '0;
              state_d = WR_DATA;
            end else if (is_digit || is_cmd) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          WR_DATA: begin
            if (is_digit) begin
              if ((cnt_q == CNT_MAX) || (acc_next > DATA_MAX)) begin
                err_d   = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
              end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else if (key_code == KEY_ENTER) begin
              if (cnt_q != '0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = acc_q[DATA_W-1:0];
              end else begin
                err_d = 1'b1;
              end
              state_d = IDLE;
            end else if (is_cmd) begin
              // REG/WRITE abort the write; they do not open a new sequence.
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      isreg    <= 1'b0;
      regvalue <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      isreg    <= isreg_d;
      regvalue <= regvalue_d;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_key_sequencer.sv
// Self-checking bench for reg_key_sequencer: key-press vector table with a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_reg_key_sequencer;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_strobe = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       isreg, wr_en, err, busy;
  logic [2:0] regvalue, wr_addr;
  logic [7:0] wr_data;

  reg_key_sequencer #(.DATA_W(8), .MAX_DIGITS(3)) dut (
    .clk(tb_clk), .rst(rst), .key_strobe(key_strobe), .key_code(key_code),
    .isreg(isreg), .regvalue(regvalue), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .err(err)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct packed {
    logic       isreg;
    logic [2:0] regvalue;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       err;
    logic       busy;
  } obs_t;

  typedef struct {
    string      name;
    logic       stb;
    logic [3:0] key;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic obs_t observe();
    obs_t o;
    o = {isreg, regvalue, wr_en, wr_addr, wr_data, err, busy};
    return o;
  endfunction

  function automatic void add(string name, logic stb, logic [3:0] key,
                              logic ir, logic [2:0] rv, logic we,
                              logic [2:0] wa, logic [7:0] wd,
                              logic er, logic bz);
    vec_t v;
    v.name = name;
    v.stb  = stb;
    v.key  = key;
    v.exp  = {ir, rv, we, wa, wd, er, bz};
    vecs.push_back(v);
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got isreg=%0d rv=%0d wr_en=%0d wa=%0d wd=%0d err=%0d busy=%0d, expected isreg=%0d rv=%0d wr_en=%0d wa=%0d wd=%0d err=%0d busy=%0d",
               name, act.isreg, act.regvalue, act.wr_en, act.wr_addr, act.wr_data,
               act.err, act.busy, exp.isreg, exp.regvalue, exp.wr_en, exp.wr_addr,
               exp.wr_data, exp.err, exp.busy);
    end
  endtask

  // Drive one cycle of input, queue its expectation, compare just after the edge.
  task automatic step(string name, logic stb, logic [3:0] key, obs_t exp);
    key_strobe = stb;
    key_code   = key;
    sb.push_back(exp);
    @(posedge tb_clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, observe(), sb.pop_front());
    end
  endtask

  initial begin
    //    name          stb key   ir rv we wa wd   er bz
    add("rd_reg",      1, 4'hA, 0, 0, 0, 0, 0,   0, 1);
    add("rd_idx5",     1, 4'h5, 1, 5, 0, 0, 0,   0, 0);
    add("idle_gap",    0, 4'hA, 0, 5, 0, 0, 0,   0, 0);
    add("wr_key",      1, 4'hB, 0, 5, 0, 0, 0,   0, 1);
    add("wr_idx3",     1, 4'h3, 0, 5, 0, 0, 0,   0, 1);
    add("wr_d2",       1, 4'h2, 0, 5, 0, 0, 0,   0, 1);
    add("wr_d5",       1, 4'h5, 0, 5, 0, 0, 0,   0, 1);
    add("wr_d5b",      1, 4'h5, 0, 5, 0, 0, 0,   0, 1);
    add("wr_enter255", 1, 4'hC, 0, 5, 1, 3, 255, 0, 0);
    add("ovf_wr",      1, 4'hB, 0, 5, 0, 3, 255, 0, 1);
    add("ovf_idx1",    1, 4'h1, 0, 5, 0, 3, 255, 0, 1);
    add("ovf_d2",      1, 4'h2, 0, 5, 0, 3, 255, 0, 1);
    add("ovf_d5",      1, 4'h5, 0, 5, 0, 3, 255, 0, 1);
    add("ovf_d6_256",  1, 4'h6, 0, 5, 0, 3, 255, 1, 0);
    add("cnt_wr",      1, 4'hB, 0, 5, 0, 3, 255, 0, 1);
    add("cnt_idx1",    1, 4'h1, 0, 5, 0, 3, 255, 0, 1);
    add("cnt_d1",      1, 4'h1, 0, 5, 0, 3, 255, 0, 1);
    add("cnt_d2",      1, 4'h2, 0, 5, 0, 3, 255, 0, 1);
    add("cnt_d3",      1, 4'h3, 0, 5, 0, 3, 255, 0, 1);
    add("cnt_d4_err",  1, 4'h4, 0, 5, 0, 3, 255, 1, 0);
    add("ill_reg",     1, 4'hA, 0, 5, 0, 3, 255, 0, 1);
    add("ill_rd9",     1, 4'h9, 0, 5, 0, 3, 255, 1, 0);
    add("ill_wr",      1, 4'hB, 0, 5, 0, 3, 255, 0, 1);
    add("ill_idx2",    1, 4'h2, 0, 5, 0, 3, 255, 0, 1);
    add("ill_enter0",  1, 4'hC, 0, 5, 0, 3, 255, 1, 0);
    add("idle_d7",     1, 4'h7, 0, 5, 0, 3, 255, 0, 0);
    add("idle_enter",  1, 4'hC, 0, 5, 0, 3, 255, 0, 0);
    add("idle_codeE",  1, 4'hE, 0, 5, 0, 3, 255, 0, 0);
    add("idle_clear",  1, 4'hD, 0, 5, 0, 3, 255, 0, 0);
    add("clr_wr",      1, 4'hB, 0, 5, 0, 3, 255, 0, 1);
    add("clr_idx4",    1, 4'h4, 0, 5, 0, 3, 255, 0, 1);
    add("clr_d7",      1, 4'h7, 0, 5, 0, 3, 255, 0, 1);
    add("clr_clear",   1, 4'hD, 0, 5, 0, 3, 255, 0, 0);
    add("rd0_reg",     1, 4'hA, 0, 5, 0, 3, 255, 0, 1);
    add("rd0_idx0",    1, 4'h0, 1, 0, 0, 3, 255, 0, 0);
    add("rdF_reg",     1, 4'hA, 0, 0, 0, 3, 255, 0, 1);
    add("rdF_codeF",   1, 4'hF, 0, 0, 0, 3, 255, 0, 1);
    add("rdF_idx2",    1, 4'h2, 1, 2, 0, 3, 255, 0, 0);
    add("idx8_wr",     1, 4'hB, 0, 2, 0, 3, 255, 0, 1);
    add("idx8_err",    1, 4'h8, 0, 2, 0, 3, 255, 1, 0);
    add("wrreg_wr",    1, 4'hB, 0, 2, 0, 3, 255, 0, 1);
    add("wrreg_idx6",  1, 4'h6, 0, 2, 0, 3, 255, 0, 1);
    add("wrreg_reg",   1, 4'hA, 0, 2, 0, 3, 255, 1, 0);
    add("wrreg_d7",    1, 4'h7, 0, 2, 0, 3, 255, 0, 0);
    add("wr0_wr",      1, 4'hB, 0, 2, 0, 3, 255, 0, 1);
    add("wr0_idx0",    1, 4'h0, 0, 2, 0, 3, 255, 0, 1);
    add("wr0_d0",      1, 4'h0, 0, 2, 0, 3, 255, 0, 1);
    add("wr0_enter",   1, 4'hC, 0, 2, 1, 0, 0,   0, 0);
    add("wr7_wr",      1, 4'hB, 0, 2, 0, 0, 0,   0, 1);
    add("wr7_idx7",    1, 4'h7, 0, 2, 0, 0, 0,   0, 1);
    add("wr7_d0",      1, 4'h0, 0, 2, 0, 0, 0,   0, 1);
    add("wr7_d0b",     1, 4'h0, 0, 2, 0, 0, 0,   0, 1);
    add("wr7_d9",      1, 4'h9, 0, 2, 0, 0, 0,   0, 1);
    add("wr7_enter",   1, 4'hC, 0, 2, 1, 7, 9,   0, 0);
    add("hold_gap",    0, 4'hC, 0, 2, 0, 7, 9,   0, 0);

    // Reset state while rst is held low.
    #12;
    check("reset_state", observe(), obs_t'(0));
    rst = 1'b1;
    @(posedge tb_clk);
    #1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].stb, vecs[i].key, vecs[i].exp);

    // Asynchronous reset mid-sequence (WRITE, 6), between clock edges.
    step("ar_wr",   1'b1, 4'hB, {1'b0, 3'd2, 1'b0, 3'd7, 8'd9, 1'b0, 1'b1});
    step("ar_idx6", 1'b1, 4'h6, {1'b0, 3'd2, 1'b0, 3'd7, 8'd9, 1'b0, 1'b1});
    key_strobe = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("ar_immediate", observe(), obs_t'(0));
    @(posedge tb_clk);
    #1;
    check("ar_held", observe(), obs_t'(0));
    rst = 1'b1;
    step("ar_enter_ignored", 1'b1, 4'hC, obs_t'(0));
    step("ar_rd_reg",        1'b1, 4'hA, {1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1});
    step("ar_rd_idx3",       1'b1, 4'h3, {1'b1, 3'd3, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0});
    step("ar_tail",          1'b0, 4'h0, {1'b0, 3'd3, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0});

    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
